// File: rtl/ab_read_scheduler_if.sv
`default_nettype none
// ============================================================================
// ab_read_scheduler_if : handshake and address bundle between the A/B read
//                        scheduler, the scoring datapath and the traceback unit.
// Rev 1.0
// ============================================================================
interface ab_read_scheduler_if #(
  parameter int IDX_W = 9
);
  logic             start;
  logic             abort;
  logic             cell_ack;
  logic             tb_valid;
  logic [IDX_W-1:0] i_t;
  logic [IDX_W-1:0] j_t;

  logic             en_read;
  logic             en_traceB;
  logic             change_index;
  logic [IDX_W-1:0] i;
  logic [IDX_W-1:0] j;
  logic [IDX_W-1:0] index_a;
  logic [IDX_W-1:0] index_b;
  logic             busy;
  logic             fill_done;
  logic             done;

  modport slave (
    input  start, abort, cell_ack, tb_valid, i_t, j_t,
    output en_read, en_traceB, change_index, i, j, index_a, index_b,
           busy, fill_done, done
  );

  modport master (
    output start, abort, cell_ack, tb_valid, i_t, j_t,
    input  en_read, en_traceB, change_index, i, j, index_a, index_b,
           busy, fill_done, done
  );
endinterface
`default_nettype wire

// File: rtl/ab_read_scheduler.sv
`default_nettype none
// ============================================================================
// ab_read_scheduler : walks the Needleman-Wunsch fill in row-major order and
//                     passes traceback coordinates through to the A/B RAMs.
// Rev 1.0
// ============================================================================
module ab_read_scheduler #(
  parameter int N        = 128,
  parameter int BIT_ADDR = $clog2(N + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  ab_read_scheduler_if.slave sched_io
);

  localparam int               IDX_W  = BIT_ADDR + 1;
  localparam logic [IDX_W-1:0] C_N    = IDX_W'(N);
  localparam logic [IDX_W-1:0] C_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] C_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL_READ = 3'd1,
    S_FILL_WAIT = 3'd2,
    S_ADVANCE   = 3'd3,
    S_TRACE     = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] i_q;
  logic [IDX_W-1:0] j_q;
  logic [IDX_W-1:0] index_a_q;
  logic [IDX_W-1:0] index_b_q;
  logic             en_read_q;
  logic             en_traceb_q;
  logic             change_index_q;
  logic             busy_q;
  logic             fill_done_q;
  logic             done_q;

  logic [IDX_W-1:0] i_d;
  logic [IDX_W-1:0] j_d;
  logic             last_cell;
  logic             tb_terminal;

  // Row-major successor of the current cell; saturates at (N, N).
  always_comb begin
    i_d       = i_q;
    j_d       = j_q;
    last_cell = (i_q == C_N) && (j_q == C_N);
    if (j_q < C_N) begin
      j_d = j_q + C_ONE;
    end else if (i_q < C_N) begin
      j_d = C_ONE;
      i_d = i_q + C_ONE;
    end
  end

  assign tb_terminal = sched_io.tb_valid &&
                       ((sched_io.i_t == C_ZERO) || (sched_io.j_t == C_ZERO));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      i_q            <= '0;
      j_q            <= '0;
      index_a_q      <= '0;
      index_b_q      <= '0;
      en_read_q      <= 1'b0;
      en_traceb_q    <= 1'b0;
      change_index_q <= 1'b0;
      busy_q         <= 1'b0;
      fill_done_q    <= 1'b0;
      done_q         <= 1'b0;
    end else if (sched_io.abort) begin
      state_q        <= S_IDLE;
      i_q            <= '0;
      j_q            <= '0;
      index_a_q      <= '0;
      index_b_q      <= '0;
      en_read_q      <= 1'b0;
      en_traceb_q    <= 1'b0;
      change_index_q <= 1'b0;
      busy_q         <= 1'b0;
      fill_done_q    <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      change_index_q <= 1'b0;
      fill_done_q    <= 1'b0;
      done_q         <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sched_io.start) begin
            state_q   <= S_FILL_READ;
            i_q       <= C_ONE;
            j_q       <= C_ONE;
            index_a_q <= C_ONE;
            index_b_q <= C_ONE;
            en_read_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_FILL_READ: begin
          state_q <= S_FILL_WAIT;
        end
        S_FILL_WAIT: begin
          if (sched_io.cell_ack) begin
            state_q        <= S_ADVANCE;
            change_index_q <= 1'b1;
          end
        end
        S_ADVANCE: begin
          if (last_cell) begin
            state_q     <= S_TRACE;
            en_read_q   <= 1'b0;
            en_traceb_q <= 1'b1;
            fill_done_q <= 1'b1;
          end else begin
            // Counters and RAM addresses move together so FILL_READ sees the new cell.
            state_q   <= S_FILL_READ;
            i_q       <= i_d;
            j_q       <= j_d;
            index_a_q <= i_d;
            index_b_q <= j_d;
          end
        end
        S_TRACE: begin
          if (sched_io.tb_valid) begin
            index_a_q <= sched_io.i_t;
            index_b_q <= sched_io.j_t;
            if (tb_terminal) begin
              state_q     <= S_DONE;
              en_traceb_q <= 1'b0;
            end
          end
        end
        S_DONE: begin
          // done and the busy drop share the edge that returns to IDLE.
          state_q   <= S_IDLE;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          i_q       <= '0;
          j_q       <= '0;
          index_a_q <= '0;
          index_b_q <= '0;
        end
        default: begin
          state_q     <= S_IDLE;
          en_read_q   <= 1'b0;
          en_traceb_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign sched_io.en_read      = en_read_q;
  assign sched_io.en_traceB    = en_traceb_q;
  assign sched_io.change_index = change_index_q;
  assign sched_io.i            = i_q;
  assign sched_io.j            = j_q;
  assign sched_io.index_a      = index_a_q;
  assign sched_io.index_b      = index_b_q;
  assign sched_io.busy         = busy_q;
  assign sched_io.fill_done    = fill_done_q;
  assign sched_io.done         = done_q;

  a_read_trace_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(en_read_q && en_traceb_q));
  a_counter_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (i_q <= C_N) && (j_q <= C_N));
  a_change_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
    change_index_q |=> !change_index_q);
  a_fill_done_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fill_done_q |=> !fill_done_q);

endmodule
`default_nettype wire

// File: tb/tb_ab_read_scheduler.sv
`default_nettype none
// ============================================================================
// tb_ab_read_scheduler : randomized scoreboard bench for ab_read_scheduler.
// Rev 1.0
// ============================================================================
module tb_ab_read_scheduler;

  localparam int N = 4;
  localparam int W = $clog2(N + 1) + 1;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } cell_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         term;
  } trc_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_done = 0;
  int   n_fd = 0;

  cell_t exp_cell[$];
  trc_t  exp_trc[$];

  ab_read_scheduler_if #(.IDX_W(W)) sif ();

  ab_read_scheduler #(.N(N)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .sched_io(sif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference fill order: plain row-major enumeration of the first `count` cells.
  task automatic push_fill(int count);
    int k = 0;
    cell_t c;
    for (int r = 1; r <= N; r++) begin
      for (int col = 1; col <= N; col++) begin
        if (k < count) begin
          c.a = W'(r);
          c.b = W'(col);
          exp_cell.push_back(c);
        end
        k++;
      end
    end
  endtask

  task automatic send_tb(int a, int b);
    trc_t t;
    t.a  = W'(a);
    t.b  = W'(b);
    t.term = (a == 0) || (b == 0);
    exp_trc.push_back(t);
    sif.tb_valid = 1'b1;
    sif.i_t      = W'(a);
    sif.j_t      = W'(b);
    tick();
    sif.tb_valid = 1'b0;
  endtask

  task automatic wait_fill_done(bit rand_ack);
    int budget = 2000;
    while (!sif.fill_done && budget > 0) begin
      if (rand_ack) sif.cell_ack = 1'($urandom_range(0, 1));
      tick();
      budget--;
    end
    check("fill_done_seen", 32'(sif.fill_done), 32'd1);
    sif.cell_ack = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 10;
    while (sif.busy && budget > 0) begin
      tick();
      budget--;
    end
    check("return_idle", 32'(sif.busy), 32'd0);
  endtask

  task automatic start_run();
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    check("start_en_read", 32'(sif.en_read), 32'd1);
    check("start_ij", {sif.i, sif.j}, {W'(1), W'(1)});
    check("start_index", {sif.index_a, sif.index_b}, {W'(1), W'(1)});
    check("start_busy", 32'(sif.busy), 32'd1);
  endtask

  task automatic random_trace();
    int a = N;
    int b = N;
    send_tb(a, b);
    while (a != 0 && b != 0) begin
      repeat ($urandom_range(0, 2)) tick();
      case ($urandom_range(0, 2))
        0: begin a--; b--; end
        1: a--;
        default: b--;
      endcase
      send_tb(a, b);
    end
  endtask

  task automatic check_all_zero(string name);
    check(name, {sif.en_read, sif.en_traceB, sif.change_index, sif.busy,
                 sif.fill_done, sif.done, sif.i, sif.j, sif.index_a, sif.index_b}, 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a fill cell or a traceback address.
  initial begin : monitor
    bit           pend;
    bit           done_due;
    logic [W-1:0] last_a;
    logic [W-1:0] last_b;
    cell_t        c;
    trc_t         t;
    pend = 1'b0;
    done_due = 1'b0;
    last_a = '0;
    last_b = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
        done_due = 1'b0;
      end else begin
        if (sif.done) n_done++;
        if (done_due) begin
          check("done_pulse", {sif.done, sif.busy, sif.en_traceB}, 3'b100);
          done_due = 1'b0;
        end else if (sif.done) begin
          check("spurious_done", 32'(sif.done), 32'd0);
        end
        if (sif.fill_done) begin
          n_fd++;
          check("fill_done_state", {sif.en_read, sif.en_traceB, sif.i, sif.j},
                {1'b0, 1'b1, W'(N), W'(N)});
          check("cells_left_at_fill_done", exp_cell.size(), 32'd0);
          last_a = W'(N);
          last_b = W'(N);
        end
        if (sif.change_index) begin
          if (exp_cell.size() == 0) begin
            check("unexpected_change_index", 32'd1, 32'd0);
          end else begin
            c = exp_cell.pop_front();
            check("fill_cell", {sif.index_a, sif.index_b, sif.i, sif.j, sif.en_read},
                  {c.a, c.b, c.a, c.b, 1'b1});
          end
        end
        if (pend) begin
          if (exp_trc.size() == 0) begin
            check("unexpected_trace", 32'd1, 32'd0);
          end else begin
            t = exp_trc.pop_front();
            check("trace_index", {sif.index_a, sif.index_b}, {t.a, t.b});
            check("trace_en", 32'(sif.en_traceB), 32'(!t.term));
            last_a = t.a;
            last_b = t.b;
            if (t.term) done_due = 1'b1;
          end
        end else if (sif.en_traceB) begin
          check("trace_hold", {sif.index_a, sif.index_b}, {last_a, last_b});
        end
        pend = sif.en_traceB && sif.tb_valid;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int base_done;
    int base_fd;
    int t0;
    int budget;

    rst_n        = 1'b0;
    sif.start    = 1'b0;
    sif.abort    = 1'b0;
    sif.cell_ack = 1'b0;
    sif.tb_valid = 1'b0;
    sif.i_t      = '0;
    sif.j_t      = '0;
    #12;
    check_all_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_all_zero("idle_outputs");

    // Delayed ack, ack during FILL_READ, then the fixed traceback path.
    base_done = n_done;
    base_fd   = n_fd;
    push_fill(N * N);
    start_run();
    sif.cell_ack = 1'b1;
    tick();
    sif.cell_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_hold", {sif.change_index, sif.en_read, sif.index_a, sif.index_b},
            {1'b0, 1'b1, W'(1), W'(1)});
      tick();
    end
    wait_fill_done(1'b1);
    send_tb(4, 4);
    send_tb(3, 3);
    tick();
    tick();
    send_tb(2, 2);
    send_tb(1, 2);
    send_tb(0, 1);
    wait_idle();
    tick();
    check("run1_done_count", n_done - base_done, 32'd1);
    check("run1_fill_done_count", n_fd - base_fd, 32'd1);
    check("run1_trace_left", exp_trc.size(), 32'd0);
    check_all_zero("run1_idle");

    // Back-to-back acks give exactly three cycles per cell; then an immediate terminal.
    base_done = n_done;
    push_fill(N * N);
    sif.cell_ack = 1'b1;
    start_run();
    t0 = cyc;
    wait_fill_done(1'b0);
    check("fill_latency", cyc - t0, 32'(3 * N * N));
    send_tb(0, 3);
    wait_idle();
    tick();
    check("run2_done_count", n_done - base_done, 32'd1);

    // Randomized fills and traceback walks; each restart begins at (1,1).
    for (int r = 0; r < 3; r++) begin
      base_done = n_done;
      push_fill(N * N);
      start_run();
      wait_fill_done(1'b1);
      random_trace();
      wait_idle();
      tick();
      check("rand_done_count", n_done - base_done, 32'd1);
      check("rand_trace_left", exp_trc.size(), 32'd0);
    end

    // Abort while waiting on cell (2,3).
    base_done = n_done;
    base_fd   = n_fd;
    push_fill(N + 2);
    sif.cell_ack = 1'b1;
    start_run();
    budget = 200;
    while (!(sif.index_a == W'(2) && sif.index_b == W'(3)) && budget > 0) begin
      tick();
      budget--;
    end
    check("reach_cell_2_3", {sif.index_a, sif.index_b}, {W'(2), W'(3)});
    sif.cell_ack = 1'b0;
    repeat (3) tick();
    check("pre_abort_wait", {sif.en_read, sif.change_index, sif.busy}, 3'b101);
    sif.abort = 1'b1;
    tick();
    sif.abort = 1'b0;
    check_all_zero("abort_idle");
    repeat (4) tick();
    check("abort_no_done", n_done - base_done, 32'd0);
    check("abort_no_fill_done", n_fd - base_fd, 32'd0);
    check("abort_cells_left", exp_cell.size(), 32'd0);

    // Asynchronous reset while in TRACE.
    push_fill(N * N);
    sif.cell_ack = 1'b1;
    start_run();
    wait_fill_done(1'b0);
    send_tb(3, 2);
    tick();
    rst_n = 1'b0;
    #2;
    check_all_zero("async_reset_trace");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_all_zero("after_reset_idle");
    check("reset_trace_left", exp_trc.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
